// File: rtl/aes_inv_cipher_top.sv
// ---------------------------------------------------------------------------
// aes_inv_cipher_top
// Iterative AES-128 decryption core, one round per clock. A key load expands
// all eleven round keys into a local store (one key per cycle). Decryption
// then walks that store from rk10 down to rk0.
//
// Ports
//   clk      : core clock, rising edge
//   rst      : synchronous reset, active-low
//   kld      : key-load strobe, samples key and starts expansion
//   key      : 128-bit cipher key, byte 0 in [127:120]
//   ld       : block-load strobe, samples text_in and starts decryption
//   text_in  : 128-bit ciphertext, byte 0 in [127:120]
//   text_out : 128-bit plaintext, registered, held until the next completion
//   done     : one-cycle pulse marking a new text_out
//   kdone    : level, round-key store complete and usable
// ---------------------------------------------------------------------------
module aes_inv_cipher_top #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          kld,
  input  logic [KW-1:0] key,
  input  logic          ld,
  input  logic [KW-1:0] text_in,
  output logic [KW-1:0] text_out,
  output logic          done,
  output logic          kdone
);

  typedef enum logic [1:0] {IDLE, KEXP, DEC} state_e;

  // ---------------------------------------------------------------------
  // GF(2^8) helpers, polynomial 0x11b
  // ---------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] e;
    r = 8'h01;
    e = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (e[i]) r = gf_mul(r, a);
    end
    return r;
  endfunction

  // S-boxes built from the field inverse plus the affine map, rather than
  // from lookup tables.
  function automatic logic [7:0] aes_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] aes_inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One step of the forward key schedule: previous round key -> next.
  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {aes_sbox(w3[23:16]), aes_sbox(w3[15:8]), aes_sbox(w3[7:0]),
          aes_sbox(w3[31:24])} ^ {rc, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte b = 4*col + row lives at bits [127-8b -: 8]; row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int b = 0; b < 16; b++) begin
      o[127-8*b -: 8] = aes_inv_sbox(s[127-8*b -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          kdone_q, kdone_d;
  logic          done_q, done_d;
  logic [KW-1:0] text_out_q, text_out_d;
  logic [KW-1:0] st_q, st_d;
  logic [KW-1:0] wk_q, wk_d;
  logic [KW-1:0] rk_q [0:NR];

  logic          rk_we;
  logic [3:0]    rk_idx;
  logic [KW-1:0] rk_wdata;

  logic [KW-1:0] key_next;
  logic [KW-1:0] round_key;
  logic [KW-1:0] inv_core;
  logic [KW-1:0] round_out;

  // cnt_q doubles as the round index for both expansion and decryption.
  assign key_next  = key_step(wk_q, rcon(cnt_q));
  assign round_key = rk_q[cnt_q];
  assign inv_core  = inv_sub_bytes(inv_shift_rows(st_q)) ^ round_key;
  assign round_out = inv_mix_columns(inv_core);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    kdone_d    = kdone_q;
    done_d     = 1'b0;
    text_out_d = text_out_q;
    st_d       = st_q;
    wk_d       = wk_q;
    rk_we      = 1'b0;
    rk_idx     = 4'd0;
    rk_wdata   = '0;

    // kld overrides everything, including an in-flight decryption or expansion.
    if (kld) begin
      rk_we    = 1'b1;
      rk_idx   = 4'd0;
      rk_wdata = key;
      wk_d     = key;
      cnt_d    = 4'd1;
      kdone_d  = 1'b0;
      state_d  = KEXP;
    end else begin
      case (state_q)
        IDLE: begin
          if (ld && kdone_q) begin
            st_d    = text_in ^ rk_q[NR];
            cnt_d   = 4'(NR - 1);
            state_d = DEC;
          end
        end
        KEXP: begin
          rk_we    = 1'b1;
          rk_idx   = cnt_q;
          rk_wdata = key_next;
          wk_d     = key_next;
          if (cnt_q == 4'(NR)) begin
            cnt_d   = 4'd0;
            kdone_d = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        DEC: begin
          if (cnt_q != 4'd0) begin
            st_d  = round_out;
            cnt_d = cnt_q - 4'd1;
          end else begin
            // Final round: no InvMixColumns, round_key is rk0 here.
            text_out_d = inv_core;
            done_d     = 1'b1;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and visible outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      kdone_q    <= 1'b0;
      done_q     <= 1'b0;
      text_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      kdone_q    <= kdone_d;
      done_q     <= done_d;
      text_out_q <= text_out_d;
    end
  end

  // Datapath registers; contents are meaningless until the FSM loads them.
  always_ff @(posedge clk) begin
    st_q <= st_d;
    wk_q <= wk_d;
    if (rk_we) rk_q[rk_idx] <= rk_wdata;
  end

  assign text_out = text_out_q;
  assign done     = done_q;
  assign kdone    = kdone_q;

endmodule

// File: tb/tb_aes_inv_cipher_top.sv
module tb_aes_inv_cipher_top;

  logic         clk = 1'b0;
  logic         rst, kld, ld, done, kdone;
  logic [127:0] key, text_in, text_out;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  logic [7:0] sbox [256];

  localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2A = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2A = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2B = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT2B = 128'h6bc1bee22e409f96e93d7e117393172a;

  aes_inv_cipher_top #(.NR(10), .KW(128)) dut (
    .clk(clk), .rst(rst), .kld(kld), .key(key), .ld(ld), .text_in(text_in),
    .text_out(text_out), .done(done), .kdone(kdone)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  // -------------------------------------------------------------------
  // Reference encryptor (forward cipher), S-box from the p/q generator
  // -------------------------------------------------------------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int s);
    logic [15:0] d;
    d = {x, x} << s;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  function automatic logic [127:0] enc(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int b = 0; b < 16; b++) t[b] = sbox[s[b]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*r + b/4][31-8*(b%4) -: 8];
    end
    o = '0;
    for (int b = 0; b < 16; b++) o[127-8*b -: 8] = s[b];
    return o;
  endfunction

  // -------------------------------------------------------------------
  // Checking and stimulus tasks
  // -------------------------------------------------------------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    kld = 1'b1;
    key = k;
    @(negedge clk);
    kld = 1'b0;
  endtask

  // Counts cycles until kdone rises; exp is the expected count.
  task automatic wait_kdone(input string tag, input int exp);
    int lat;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (kdone === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk(tag, lat, exp);
  endtask

  task automatic start_ld(input logic [127:0] ct);
    ld      = 1'b1;
    text_in = ct;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic decrypt(input string tag, input logic [127:0] ct, input logic [127:0] pt);
    int lat;
    start_ld(ct);
    wait_done(lat);
    chk({tag, "_lat"}, lat, 10);
    chk({tag, "_pt"}, text_out, pt);
    @(negedge clk);
    chk({tag, "_pulse"}, done, 0);
  endtask

  // -------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------
  initial begin
    int lat, d0, n0;
    logic [127:0] rk, rp, ct_x;

    build_sbox();
    rst = 1'b0; kld = 1'b0; ld = 1'b0; key = '0; text_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_text_out", text_out, 0);
    chk("rst_done", done, 0);
    chk("rst_kdone", kdone, 0);
    rst = 1'b1;

    // 1: FIPS-197 vector
    load_key(K1);
    chk("t1_kdone_low", kdone, 0);
    wait_kdone("t1_kexp_lat", 10);
    decrypt("t1", CT1, PT1);

    // 2: new key, then back-to-back block loaded in the done cycle
    load_key(K2);
    wait_kdone("t2_kexp_lat", 10);
    start_ld(CT2A);
    wait_done(lat);
    chk("t2a_lat", lat, 10);
    chk("t2a_pt", text_out, PT2A);
    start_ld(CT2B);
    wait_done(lat);
    chk("t2b_lat_after_done", lat + 1, 11);
    chk("t2b_pt", text_out, PT2B);
    @(negedge clk);
    chk("t2b_pulse", done, 0);

    // 3: ld during KEXP and mid-DEC are ignored
    load_key(K1);
    repeat (3) @(negedge clk);
    ld = 1'b1; text_in = CT2A;
    @(negedge clk);
    ld = 1'b0;
    wait_kdone("t3_kexp_lat", 6);
    d0 = done_cnt;
    start_ld(CT1);
    repeat (3) @(negedge clk);
    ld = 1'b1; text_in = CT2A;
    @(negedge clk);
    ld = 1'b0;
    wait_done(lat);
    chk("t3_lat", lat, 6);
    chk("t3_pt", text_out, PT1);
    repeat (15) @(negedge clk);
    chk("t3_one_done", done_cnt - d0, 1);

    // 4: kld at cycle 5 of DEC aborts the block
    ct_x = enc(K1, 128'h0123456789abcdeffedcba9876543210);
    d0 = done_cnt;
    start_ld(ct_x);
    repeat (4) @(negedge clk);
    kld = 1'b1; key = K2;
    @(negedge clk);
    kld = 1'b0;
    chk("t4_kdone_low", kdone, 0);
    n0 = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (kdone === 1'b1) break;
      n0++;
    end
    chk("t4_kdone_low_cycles", n0, 10);
    chk("t4_text_hold", text_out, PT1);
    chk("t4_no_done", done_cnt - d0, 0);
    decrypt("t4", CT2A, PT2A);

    // 5: reset mid-DEC and mid-KEXP
    start_ld(CT2B);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("t5_dec_rst_text", text_out, 0);
    chk("t5_dec_rst_done", done, 0);
    chk("t5_dec_rst_kdone", kdone, 0);
    d0 = done_cnt;
    start_ld(CT2A);
    repeat (15) @(negedge clk);
    chk("t5_ld_ignored", done_cnt - d0, 0);
    chk("t5_text_zero", text_out, 0);
    load_key(K1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("t5_kexp_rst_kdone", kdone, 0);
    repeat (15) @(negedge clk);
    chk("t5_kdone_stays_low", kdone, 0);
    d0 = done_cnt;
    start_ld(CT1);
    repeat (15) @(negedge clk);
    chk("t5_ld_ignored2", done_cnt - d0, 0);
    load_key(K1);
    wait_kdone("t5_kexp_lat", 10);
    decrypt("t5", CT1, PT1);

    // 6: round-trip against the reference encryptor
    for (int n = 0; n < 200; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      load_key(rk);
      wait_kdone("t6_kexp_lat", 10);
      decrypt("t6", enc(rk, rp), rp);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
